// File: rtl/dtw_axis_sample_unpacker_pkg.sv
// Shared types and width helpers for the DTW AXI4-Stream sample unpacker.
// Build option: DTW_AXIS_STRB_EN (TSTRB lane qualification, see top level).
package dtw_axis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int lanes_of(input int data_width, input int sample_width);
        return data_width / sample_width;
    endfunction

    // Count must represent 0..depth inclusive, hence depth+1.
    function automatic int cw_of(input int depth);
        return clog2(depth + 1);
    endfunction

    // FIFO entry layout is {last, sample}: the packet-end flag sits above the sample.
    localparam int ENTRY_LAST_BITS = 1;

    function automatic int entry_width(input int sample_width);
        return sample_width + ENTRY_LAST_BITS;
    endfunction

endpackage

// File: rtl/dtw_axis_sample_unpacker_if.sv
// AXI4-Stream beat bundle. Valid/ready: a beat transfers on a clock edge where
// TVALID && TREADY; the master holds TDATA/TSTRB/TLAST stable while TVALID waits.
interface dtw_axis_sample_unpacker_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                    TVALID;
    logic                    TREADY;
    logic [DATA_WIDTH-1:0]   TDATA;
    logic [DATA_WIDTH/8-1:0] TSTRB;
    logic                    TLAST;

    modport master (output TVALID, output TDATA, output TSTRB, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TSTRB, input TLAST, output TREADY);
endinterface

// File: rtl/dtw_axis_sample_unpacker_fifo.sv
// First-word-fall-through sample FIFO: head entry is visible on o_rd_data
// whenever not empty, and reads as zero when empty.
module dtw_sample_fifo
    import dtw_axis_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW = clog2(DEPTH),
    localparam int CW = cw_of(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A write is refused when full even if a read frees a slot the same cycle.
    assign w_wr_ok = i_wr_en && !o_full && !i_rst;
    assign w_rd_ok = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
            if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/dtw_axis_sample_unpacker.sv
// AXI4-Stream sink that splits wide beats into samples for the DTW core FIFO.
// Define DTW_AXIS_STRB_EN to qualify lanes with TSTRB and enable dtw_null_last.
module dtw_axis_sample_unpacker
    import dtw_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 8,
    parameter int FIFO_DEPTH           = 16,
    localparam int LANES = lanes_of(C_S_AXIS_TDATA_WIDTH, SAMPLE_WIDTH),
    localparam int CW    = cw_of(FIFO_DEPTH)
) (
    input  logic                        S_AXIS_ACLK,
    input  logic                        S_AXIS_ARESET,
    dtw_axis_sample_unpacker_if.slave   S_AXIS,
    input  logic                        dtw_fifo_rden,
    output logic [SAMPLE_WIDTH-1:0]     dtw_fifo_dout,
    output logic                        dtw_fifo_last,
    output logic                        dtw_fifo_empty,
    output logic [CW-1:0]               dtw_fifo_count,
    output logic                        dtw_null_last,
    output state_t                      o_dbg_state
);
    localparam int SB = SAMPLE_WIDTH / 8;
    localparam int EW = entry_width(SAMPLE_WIDTH);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] r_data;
    logic [LANES-1:0]                r_mask;
    logic [LANES-1:0]                w_mask_nxt;
    logic [LANES-1:0]                w_beat_mask;
    logic [LANES-1:0]                w_sel_oh;
    logic                            r_last;
    logic                            r_null_last;
    logic                            w_null_nxt;
    logic                            w_full;
    logic                            w_hs;
    logic                            w_one_left;
    logic                            w_wr;
    logic                            w_wr_last;
    logic [SAMPLE_WIDTH-1:0]         w_sample;
    logic [EW-1:0]                   w_rd_entry;

`ifdef DTW_AXIS_STRB_EN
    // A lane counts only when every byte strobe covering it is set.
    always_comb begin
        w_beat_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_beat_mask[i] = &S_AXIS.TSTRB[i*SB +: SB];
        end
    end
    assign w_null_nxt = w_hs && (w_beat_mask == '0) && S_AXIS.TLAST;
`else
    logic w_unused_strb;
    assign w_unused_strb = ^S_AXIS.TSTRB;
    assign w_beat_mask   = '1;
    assign w_null_nxt    = 1'b0;
`endif

    assign w_sel_oh   = r_mask & (~r_mask + LANES'(1));
    assign w_one_left = (r_mask != '0) && ((r_mask & (r_mask - LANES'(1))) == '0);
    assign w_wr       = (r_state == UNPACK) && !w_full;
    assign w_wr_last  = r_last && w_one_left;

    // Ready while idle, or when the final held lane drains this cycle.
    assign S_AXIS.TREADY = !S_AXIS_ARESET &&
                           ((r_state == IDLE) || (w_one_left && !w_full));
    assign w_hs = S_AXIS.TVALID && S_AXIS.TREADY;

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_sel_oh[i]) w_sample = r_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        if (w_wr) w_mask_nxt = r_mask & ~w_sel_oh;
        if (w_hs) begin
            w_mask_nxt  = w_beat_mask;
            w_state_nxt = (w_beat_mask != '0) ? UNPACK : IDLE;
        end else if (w_wr && w_one_left) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_null_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_null_last <= w_null_nxt;
            if (w_hs) begin
                r_data <= S_AXIS.TDATA;
                r_last <= S_AXIS.TLAST;
            end
        end
    end

    dtw_sample_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (S_AXIS_ACLK),
        .i_rst     (S_AXIS_ARESET),
        .i_wr_en   (w_wr),
        .i_wr_data ({w_wr_last, w_sample}),
        .o_full    (w_full),
        .i_rd_en   (dtw_fifo_rden),
        .o_rd_data (w_rd_entry),
        .o_empty   (dtw_fifo_empty),
        .o_count   (dtw_fifo_count)
    );

    assign dtw_fifo_last = w_rd_entry[EW-1];
    assign dtw_fifo_dout = w_rd_entry[SAMPLE_WIDTH-1:0];
    assign dtw_null_last = r_null_last;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dtw_axis_sample_unpacker.sv
// Directed bench for dtw_axis_sample_unpacker (32-bit beats, 8-bit samples, depth 4),
// with a sample scoreboard; covers both DTW_AXIS_STRB_EN builds.
module tb_dtw_axis_sample_unpacker;
    import dtw_axis_pkg::*;

    localparam int DW    = 32;
    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int LANES = DW / SW;
    localparam int SB    = SW / 8;
    localparam int CW    = cw_of(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dtw_axis_sample_unpacker_if #(.DATA_WIDTH(DW)) s_axis ();

    logic          rden;
    logic [SW-1:0] dout;
    logic          flast;
    logic          fempty;
    logic [CW-1:0] fcount;
    logic          null_last;
    state_t        dbg_state;

    dtw_axis_sample_unpacker #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .SAMPLE_WIDTH         (SW),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .S_AXIS         (s_axis),
        .dtw_fifo_rden  (rden),
        .dtw_fifo_dout  (dout),
        .dtw_fifo_last  (flast),
        .dtw_fifo_empty (fempty),
        .dtw_fifo_count (fcount),
        .dtw_null_last  (null_last),
        .o_dbg_state    (dbg_state)
    );

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [SW:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic lane_valid(input logic [DW/8-1:0] strb, input int lane);
        logic v;
        v = &strb[lane*SB +: SB];
`ifndef DTW_AXIS_STRB_EN
        v = 1'b1;
`endif
        return v;
    endfunction

    // Expected samples of one accepted beat, lowest lane first; last on the top valid lane.
    task automatic push_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
        int final_lane;
        final_lane = -1;
        for (int i = 0; i < LANES; i++) if (lane_valid(strb, i)) final_lane = i;
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid(strb, i))
                exp_q.push_back({last && (i == final_lane), data[i*SW +: SW]});
        end
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
        logic ok;
        int   cyc;
        ok  = 1'b0;
        cyc = 0;
        s_axis.TVALID = 1'b1;
        s_axis.TDATA  = data;
        s_axis.TSTRB  = strb;
        s_axis.TLAST  = last;
        while (!ok && cyc < 200) begin
            #1;
            if (s_axis.TREADY) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (ok) begin
            @(posedge clk);
            push_beat(data, strb, last);
            @(negedge clk);
        end
        s_axis.TVALID = 1'b0;
        check("send_handshake", 32'(ok), 32'd1);
    endtask

    // Pops n samples with rden held high, comparing each head against the scoreboard.
    task automatic drain(input int n, input int budget);
        int          got;
        int          cyc;
        logic [SW:0] e;
        got  = 0;
        cyc  = 0;
        rden = 1'b1;
        while (got < n && cyc < budget) begin
            #1;
            if (!fempty) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("sample", 32'({flast, dout}), 32'(e));
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        rden = 1'b0;
        check("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SW:0] e;
        rden          = 1'b0;
        s_axis.TVALID = 1'b1;
        s_axis.TDATA  = 32'hDEADBEEF;
        s_axis.TSTRB  = '1;
        s_axis.TLAST  = 1'b0;
        rst           = 1'b1;

        // Reset with TVALID asserted
        repeat (3) begin
            @(negedge clk);
            check("rst_tready", 32'(s_axis.TREADY), 32'd0);
            check("rst_empty",  32'(fempty), 32'd1);
            check("rst_count",  32'(fcount), 32'd0);
            check("rst_dout",   32'(dout), 32'd0);
            check("rst_last",   32'(flast), 32'd0);
            check("rst_null",   32'(null_last), 32'd0);
        end
        s_axis.TVALID = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_tready", 32'(s_axis.TREADY), 32'd1);
        check("post_rst_state",  32'(dbg_state), 32'(IDLE));
        @(negedge clk);

        // Full unpack and first-sample latency
        send_beat(32'h44332211, 4'hF, 1'b1);
        check("lat_empty_n",  32'(fempty), 32'd1);
        check("lat_state",    32'(dbg_state), 32'(UNPACK));
        @(negedge clk);
        check("lat_empty_n1", 32'(fempty), 32'd0);
        check("lat_count_n1", 32'(fcount), 32'd1);
        drain(4, 20);
        check("full_empty", 32'(fempty), 32'd1);
        check("full_count", 32'(fcount), 32'd0);

`ifdef DTW_AXIS_STRB_EN
        // Sparse strobes, then a zero-mask TLAST beat
        send_beat(32'hDDCCBBAA, 4'b1010, 1'b0);
        repeat (3) @(negedge clk);
        check("sparse_count", 32'(fcount), 32'd2);
        drain(2, 10);
        send_beat(32'h12345678, 4'b0000, 1'b1);
        check("null_pulse",  32'(null_last), 32'd1);
        check("null_count",  32'(fcount), 32'd0);
        check("null_state",  32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        check("null_single", 32'(null_last), 32'd0);
        check("null_empty",  32'(fempty), 32'd1);
`else
        // Strobes ignored: zero TSTRB still delivers all lanes, no null pulse
        send_beat(32'hDDCCBBAA, 4'b0000, 1'b1);
        check("nostrb_null", 32'(null_last), 32'd0);
        repeat (4) @(negedge clk);
        check("nostrb_count", 32'(fcount), 32'd4);
        drain(4, 10);
        check("nostrb_null_after", 32'(null_last), 32'd0);
`endif

        // Full FIFO back-pressure, then drain across pointer wrap
        fork
            begin
                for (int b = 0; b < 5; b++) begin
                    send_beat({8'(b*4+3), 8'(b*4+2), 8'(b*4+1), 8'(b*4)}, 4'hF, 1'b1);
                end
            end
            begin
                repeat (30) @(negedge clk);
                #1;
                check("wrap_count_sat", 32'(fcount), 32'd4);
                check("wrap_tready",    32'(s_axis.TREADY), 32'd0);
                check("wrap_state",     32'(dbg_state), 32'(UNPACK));
                drain(20, 300);
            end
        join
        check("wrap_empty", 32'(fempty), 32'd1);
        check("wrap_sb",    32'(exp_q.size()), 32'd0);

        // Simultaneous read and write at count 2
        send_beat(32'h0D0C0B0A, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rw_count_pre", 32'(fcount), 32'd2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("rw_head", 32'({flast, dout}), 32'(e));
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        #1;
        check("rw_count_post", 32'(fcount), 32'd2);
        drain(3, 20);

        // Read while empty is ignored
        rden = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("underflow_count", 32'(fcount), 32'd0);
            check("underflow_empty", 32'(fempty), 32'd1);
        end
        rden = 1'b0;
        @(negedge clk);

        // Mid-packet reset: 3 held in FIFO, 2 lanes left in the hold register
        send_beat(32'h13121110, 4'hF, 1'b0);
        repeat (5) @(negedge clk);
        drain(3, 10);
        check("mid_pre_count", 32'(fcount), 32'd1);
        send_beat(32'h23222120, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_count3", 32'(fcount), 32'd3);
        check("mid_state",  32'(dbg_state), 32'(UNPACK));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_count",  32'(fcount), 32'd0);
        check("mid_rst_empty",  32'(fempty), 32'd1);
        check("mid_rst_tready", 32'(s_axis.TREADY), 32'd0);
        check("mid_rst_dout",   32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        send_beat(32'h00000005, 4'h1, 1'b0);
        @(negedge clk);
        #1;
        check("recover_dout",  32'(dout), 32'h05);
        check("recover_empty", 32'(fempty), 32'd0);
        drain(exp_q.size(), 20);
        check("final_sb", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
